// File: rtl/mc_pricing_sequencer_if.sv
// Pin-level bundle between the Monte-Carlo pricing sequencer and its surroundings.
// The slave modport is the sequencer's view; the master modport is the chip-side/engine view.
interface mc_pricing_sequencer_if #(
  parameter int DW     = 12,
  parameter int NPARAM = 4,
  parameter int N      = 256,
  parameter int DAY    = 8
);
  logic [1:0]             mode;
  logic [DW-1:0]          in;
  logic                   in_valid;
  logic [NPARAM*DW-1:0]   param_bus;
  logic                   sobol_start;
  logic                   gen_start;
  logic                   pricing_start;
  logic                   gen_valid;
  logic [DW-1:0]          gen_path;
  logic                   pricing_valid;
  logic [DW-1:0]          price;
  logic                   resend_req;
  logic                   valid;
  logic [DW-1:0]          out;
  logic                   resend;
  logic [$clog2(N)-1:0]   path_idx;
  logic [$clog2(DAY)-1:0] day_idx;
  logic                   err;
  logic [2:0]             fsm_state;

  modport slave (
    input  mode, in, in_valid, gen_valid, gen_path, pricing_valid, price, resend_req,
    output param_bus, sobol_start, gen_start, pricing_start, valid, out, resend,
           path_idx, day_idx, err, fsm_state
  );

  modport master (
    output mode, in, in_valid, gen_valid, gen_path, pricing_valid, price, resend_req,
    input  param_bus, sobol_start, gen_start, pricing_start, valid, out, resend,
           path_idx, day_idx, err, fsm_state
  );
endinterface

// File: rtl/mc_pricing_sequencer.sv
// Top-level control sequencer for the Monte-Carlo pricing flow: parameter capture,
// Sobol warm-up, path-generation gating, pricing hand-off and resend policing.
module mc_pricing_sequencer #(
  parameter int DW         = 12,
  parameter int DAY        = 8,
  parameter int N          = 256,
  parameter int WARMUP     = 2000,
  parameter int NPARAM     = 4,
  parameter int MAX_RESEND = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  mc_pricing_sequencer_if.slave bus
);
  localparam int PW  = $clog2(N);
  localparam int DYW = $clog2(DAY);
  localparam int WW  = $clog2(WARMUP + 1);
  localparam int IW  = $clog2(NPARAM + 1);
  localparam int RW  = $clog2(MAX_RESEND + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PARAM = 3'd1,
    S_WARM  = 3'd2,
    S_GEN   = 3'd3,
    S_PRICE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [DYW-1:0]       day_q, day_d;
  logic [PW-1:0]        path_q, path_d;
  logic [RW-1:0]        rcnt_q, rcnt_d;
  logic [NPARAM*DW-1:0] param_q, param_d;
  logic                 err_q, err_d;
  logic                 resend_q, resend_d;
  logic                 sobol_q, gen_q, pricing_q;
  logic                 abort_s;

  // Next-state and counter logic; abort (mode 0) outranks every state-specific rule.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    warm_d   = '0;
    day_d    = day_q;
    path_d   = path_q;
    rcnt_d   = rcnt_q;
    param_d  = param_q;
    err_d    = err_q;
    resend_d = 1'b0;
    abort_s  = (state_q != S_IDLE) && (bus.mode == 2'd0);
    if (abort_s) begin
      state_d = S_IDLE;
      idx_d   = '0;
      day_d   = '0;
      path_d  = '0;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.mode == 2'd1) begin
            state_d = S_PARAM;
            idx_d   = '0;
            err_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PARAM: begin
          // Words beyond NPARAM-1 are dropped; the index saturates at NPARAM.
          if (bus.in_valid && (idx_q < IW'(NPARAM))) begin
            param_d[int'(idx_q)*DW +: DW] = bus.in;
            idx_d = idx_q + 1'b1;
          end else begin
            idx_d = idx_q;
          end
          if (bus.mode == 2'd2) begin
            state_d = S_WARM;
          end else begin
            state_d = S_PARAM;
          end
        end
        S_WARM: begin
          if (warm_q == WW'(WARMUP - 1)) begin
            state_d = S_GEN;
          end else begin
            warm_d = warm_q + 1'b1;
          end
        end
        S_GEN: begin
          if (bus.mode == 2'd3) begin
            state_d = S_PRICE;
            day_d   = '0;
            path_d  = '0;
            rcnt_d  = '0;
          end else if (bus.gen_valid) begin
            if (day_q == DYW'(DAY - 1)) begin
              day_d  = '0;
              path_d = (path_q == PW'(N - 1)) ? '0 : path_q + 1'b1;
            end else begin
              day_d = day_q + 1'b1;
            end
          end else begin
            day_d = day_q;
          end
        end
        S_PRICE: begin
          if (bus.pricing_valid) begin
            state_d = S_DONE;
          end else if (bus.resend_req) begin
            resend_d = 1'b1;
            rcnt_d   = rcnt_q + 1'b1;
            if (rcnt_q == RW'(MAX_RESEND)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              state_d = S_PRICE;
            end
          end else begin
            state_d = S_PRICE;
          end
        end
        S_DONE, S_ERR: state_d = state_q;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  // State, counters and the level enables, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      warm_q    <= '0;
      day_q     <= '0;
      path_q    <= '0;
      rcnt_q    <= '0;
      param_q   <= '0;
      err_q     <= 1'b0;
      resend_q  <= 1'b0;
      sobol_q   <= 1'b0;
      gen_q     <= 1'b0;
      pricing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      warm_q    <= warm_d;
      day_q     <= day_d;
      path_q    <= path_d;
      rcnt_q    <= rcnt_d;
      param_q   <= param_d;
      err_q     <= err_d;
      resend_q  <= resend_d;
      sobol_q   <= (state_d == S_WARM) || (state_d == S_GEN) || (state_d == S_PRICE);
      gen_q     <= (state_d == S_GEN);
      pricing_q <= (state_d == S_PRICE);
    end
  end

  // Result mux is zero-latency so samples reach the pricing engine in the same cycle.
  assign bus.valid = ((state_q == S_GEN) && bus.gen_valid) ||
                     ((state_q == S_PRICE) && bus.pricing_valid);
  assign bus.out   = ((state_q == S_GEN) && bus.gen_valid)       ? bus.gen_path :
                     ((state_q == S_PRICE) && bus.pricing_valid) ? bus.price    : '0;

  assign bus.param_bus     = param_q;
  assign bus.sobol_start   = sobol_q;
  assign bus.gen_start     = gen_q;
  assign bus.pricing_start = pricing_q;
  assign bus.resend        = resend_q;
  assign bus.path_idx      = path_q;
  assign bus.day_idx       = day_q;
  assign bus.err           = err_q;
  assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_mc_pricing_sequencer.sv
// Bench for mc_pricing_sequencer: directed table/sequence tests plus a random run,
// with a cycle-level behavioural reference model checking every output each cycle.
module tb_mc_pricing_sequencer;
  localparam int DW = 12, DAY = 8, N = 256, WARMUP = 2000, NPARAM = 4, MAX_RESEND = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_pricing_sequencer_if #(.DW(DW), .NPARAM(NPARAM), .N(N), .DAY(DAY)) bus ();

  mc_pricing_sequencer #(.DW(DW), .DAY(DAY), .N(N), .WARMUP(WARMUP),
                         .NPARAM(NPARAM), .MAX_RESEND(MAX_RESEND))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int cmp_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number, parameter array, and a single sample counter
  // from which path/day are derived arithmetically.
  int             m_ph = 0;
  logic [DW-1:0]  m_prm [NPARAM];
  int             m_widx = 0, m_warm_left = 0, m_gcnt = 0, m_rs_cnt = 0;
  bit             m_err = 1'b0, m_rs = 1'b0;

  task automatic model_reset();
    m_ph = 0; m_widx = 0; m_warm_left = 0; m_gcnt = 0; m_rs_cnt = 0;
    m_err = 1'b0; m_rs = 1'b0;
    for (int i = 0; i < NPARAM; i++) m_prm[i] = '0;
  endtask

  task automatic model_step();
    m_rs = 1'b0;
    if (m_ph != 0 && bus.mode == 2'd0) begin
      m_ph = 0; m_gcnt = 0; m_rs_cnt = 0;
    end else begin
      case (m_ph)
        0: if (bus.mode == 2'd1) begin m_ph = 1; m_widx = 0; m_err = 1'b0; end
        1: begin
          if (bus.in_valid) begin
            if (m_widx < NPARAM) m_prm[m_widx] = bus.in;
            m_widx++;
          end
          if (bus.mode == 2'd2) begin m_ph = 2; m_warm_left = WARMUP; end
        end
        2: begin
          m_warm_left--;
          if (m_warm_left == 0) begin m_ph = 3; m_gcnt = 0; end
        end
        3: begin
          if (bus.gen_valid) m_gcnt = (m_gcnt + 1) % (DAY * N);
          if (bus.mode == 2'd3) begin m_ph = 4; m_gcnt = 0; m_rs_cnt = 0; end
        end
        4: begin
          if (bus.pricing_valid) m_ph = 5;
          else if (bus.resend_req) begin
            m_rs = 1'b1;
            m_rs_cnt++;
            if (m_rs_cnt == MAX_RESEND + 1) begin m_ph = 6; m_err = 1'b1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  logic [NPARAM*DW-1:0] e_bus;
  logic                 e_valid;
  logic [DW-1:0]        e_out;

  // Per-cycle comparison of every output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NPARAM; i++) e_bus[i*DW +: DW] = m_prm[i];
      e_valid = (m_ph == 3 && bus.gen_valid) || (m_ph == 4 && bus.pricing_valid);
      e_out   = (m_ph == 3 && bus.gen_valid) ? bus.gen_path :
                (m_ph == 4 && bus.pricing_valid) ? bus.price : '0;
      chk("m_state", 64'(bus.fsm_state), 64'(m_ph));
      chk("m_starts", 64'({bus.sobol_start, bus.gen_start, bus.pricing_start}),
          64'({(m_ph >= 2 && m_ph <= 4), (m_ph == 3), (m_ph == 4)}));
      chk("m_path_idx", 64'(bus.path_idx), 64'((m_gcnt / DAY) % N));
      chk("m_day_idx", 64'(bus.day_idx), 64'(m_gcnt % DAY));
      chk("m_param_bus", 64'(bus.param_bus), 64'(e_bus));
      chk("m_err_resend", 64'({bus.err, bus.resend}), 64'({m_err, m_rs}));
      chk("m_valid_out", 64'({bus.valid, bus.out}), 64'({e_valid, e_out}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int maxc, input string nm);
    int n = 0;
    while (int'(bus.fsm_state) != s && n < maxc) begin step(); n++; end
    chk(nm, 64'(bus.fsm_state), 64'(s));
  endtask

  typedef struct {
    logic [1:0]           mode;
    logic                 iv;
    logic [DW-1:0]        din;
    logic [2:0]           st;
    logic [NPARAM*DW-1:0] pb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rs_seen;
    int total;
    int len;
    int r;
    logic [DW-1:0] gp;

    tbl[0] = '{2'd1, 1'b0, 12'h000, 3'd1, 48'h000000000000};
    tbl[1] = '{2'd1, 1'b1, 12'h111, 3'd1, 48'h000000000111};
    tbl[2] = '{2'd1, 1'b1, 12'h222, 3'd1, 48'h000000222111};
    tbl[3] = '{2'd1, 1'b1, 12'h333, 3'd1, 48'h000333222111};
    tbl[4] = '{2'd1, 1'b1, 12'h444, 3'd1, 48'h444333222111};
    tbl[5] = '{2'd1, 1'b1, 12'h555, 3'd1, 48'h444333222111};
    tbl[6] = '{2'd1, 1'b0, 12'h000, 3'd1, 48'h444333222111};
    tbl[7] = '{2'd2, 1'b1, 12'h666, 3'd2, 48'h444333222111};

    bus.mode = 2'd0; bus.in = '0; bus.in_valid = 1'b0;
    bus.gen_valid = 1'b0; bus.gen_path = '0;
    bus.pricing_valid = 1'b0; bus.price = '0; bus.resend_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 64'(bus.fsm_state), 64'd0);
    chk("rst_param", 64'(bus.param_bus), 64'd0);
    chk("rst_outs", 64'({bus.sobol_start, bus.gen_start, bus.pricing_start, bus.err,
                         bus.resend, bus.path_idx, bus.day_idx}), 64'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    step();

    // T1 parameter load, then transition into warm-up
    for (int i = 0; i < 8; i++) begin
      bus.mode = tbl[i].mode; bus.in_valid = tbl[i].iv; bus.in = tbl[i].din;
      step();
      chk($sformatf("t1_state[%0d]", i), 64'(bus.fsm_state), 64'(tbl[i].st));
      chk($sformatf("t1_param[%0d]", i), 64'(bus.param_bus), 64'(tbl[i].pb));
    end
    bus.in_valid = 1'b0;

    // T2 gen_start latency from first WARM cycle
    chk("t2_sobol_on", 64'(bus.sobol_start), 64'd1);
    n = 0;
    while (!bus.gen_start && n < 3000) begin step(); n++; end
    chk("t2_warm_cycles", 64'(n), 64'(WARMUP));

    // T3 a full run of DAY*N samples
    for (int i = 0; i < DAY * N; i++) begin
      gp = DW'($urandom);
      bus.gen_valid = 1'b1; bus.gen_path = gp;
      #1;
      if (i % 256 == 0) chk("t3_out", 64'({bus.valid, bus.out}), 64'({1'b1, gp}));
      step();
      if (i == 8) chk("t3_idx9", 64'({bus.path_idx, bus.day_idx}), 64'({8'd1, 3'd1}));
    end
    bus.gen_valid = 1'b0;
    chk("t3_idx_wrap", 64'({bus.path_idx, bus.day_idx}), 64'd0);

    // T4 three resends then a price
    bus.mode = 2'd3;
    step();
    chk("t4_state", 64'(bus.fsm_state), 64'd4);
    chk("t4_starts", 64'({bus.sobol_start, bus.gen_start, bus.pricing_start}), 64'(3'b101));
    rs_seen = 0;
    for (int i = 0; i < 3; i++) begin
      bus.resend_req = 1'b1;
      step();
      bus.resend_req = 1'b0;
      if (bus.resend) rs_seen++;
      step();
    end
    chk("t4_resends", 64'(rs_seen), 64'd3);
    bus.pricing_valid = 1'b1; bus.price = 12'h7A5;
    #1;
    chk("t4_price_out", 64'({bus.valid, bus.out}), 64'({1'b1, 12'h7A5}));
    step();
    bus.pricing_valid = 1'b0;
    chk("t4_done", 64'(bus.fsm_state), 64'd5);
    chk("t4_starts_off", 64'({bus.sobol_start, bus.pricing_start}), 64'd0);

    // T5 resend overflow
    bus.mode = 2'd0; step();
    bus.mode = 2'd1; step();
    bus.mode = 2'd2;
    wait_state(3, WARMUP + 10, "t5_reach_gen");
    bus.mode = 2'd3; step();
    bus.resend_req = 1'b1;
    repeat (4) step();
    bus.resend_req = 1'b0;
    chk("t5_err_state", 64'(bus.fsm_state), 64'd6);
    chk("t5_err_flag", 64'({bus.err, bus.pricing_start}), 64'(2'b10));
    bus.pricing_valid = 1'b1; bus.price = 12'h123;
    #1;
    chk("t5_price_ignored", 64'({bus.valid, bus.out}), 64'd0);
    step();
    bus.pricing_valid = 1'b0;
    chk("t5_hold_err", 64'(bus.fsm_state), 64'd6);

    // T6 abort mid-GEN at path 17, then async reset mid-WARM
    bus.mode = 2'd0; step();
    chk("t6_err_kept", 64'({bus.fsm_state, bus.err}), 64'({3'd0, 1'b1}));
    bus.mode = 2'd1; step();
    chk("t6_err_clear", 64'(bus.err), 64'd0);
    bus.mode = 2'd2;
    wait_state(3, WARMUP + 10, "t6_reach_gen");
    bus.gen_valid = 1'b1;
    repeat (17 * DAY) step();
    bus.gen_valid = 1'b0;
    chk("t6_path17", 64'(bus.path_idx), 64'd17);
    bus.mode = 2'd0; step();
    chk("t6_abort", 64'({bus.fsm_state, bus.sobol_start, bus.gen_start, bus.pricing_start,
                         bus.path_idx}), 64'd0);
    chk("t6_param_kept", 64'(bus.param_bus), 64'h444333222111);
    bus.mode = 2'd1; step();
    bus.mode = 2'd2;
    repeat (100) step();
    chk("t6_in_warm", 64'(bus.fsm_state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rst", 64'({bus.fsm_state, bus.sobol_start, bus.param_bus}), 64'd0);
    bus.mode = 2'd0;
    step();
    rst_n = 1'b1;
    step();

    // Random segments: mode mostly walks 0->1->2->3->0, warm-up segments held long
    total = 0;
    while (total < 30000) begin
      r = int'($urandom % 8);
      if (r < 6) bus.mode = bus.mode + 2'd1;
      else bus.mode = 2'($urandom % 4);
      len = (bus.mode == 2'd2) ? int'($urandom_range(200, 3000)) : int'($urandom_range(5, 300));
      repeat (len) begin
        bus.in_valid      = 1'($urandom % 2);
        bus.in            = DW'($urandom);
        bus.gen_valid     = 1'($urandom % 2);
        bus.gen_path      = DW'($urandom);
        bus.pricing_valid = ($urandom % 16) == 0;
        bus.price         = DW'($urandom);
        bus.resend_req    = ($urandom % 4) == 0;
        step();
      end
      total += len;
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
